sram_arbiter: RTL and testbench

Shares one single-port `sram` between two requesters: the video scanout path (read-only, latency-critical) and the game-logic path (read/write). Each requester gets a req/gnt handshake and a tagged read-return. The block sits between the requesters and the `sram` instance and drives that instance's address, write strobe and write data directly. Video has priority by default, and a starvation guard guarantees game-logic progress.

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_arbiter_starve_guard.sv | 64 ++++++
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the video/game SRAM arbiter: read-return owner and
// priority FSM state. The renderer and testbench decode these as well.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_GAME  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_BOOST  = 1'b1
    } state_e;

    // A limit of 0 still needs a 1-bit counter so the vector is never empty.
    function automatic int starve_cnt_width(input int limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_starve_guard.sv
// Starvation guard: counts consecutive lost game arbitrations and raises
// boost so that game logic wins the next contested cycle.
module starve_guard
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_g_req,
    input  logic i_g_gnt,
    output logic o_boost
);

    localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam bit BOOST_EN = (STARVE_LIMIT != 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               g_served;

    assign g_served = !i_g_req || i_g_gnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = state_q;

        if (g_served) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // Entering on the next count lets the limit-th loss be followed
        // directly by a game grant.
        case (state_q)
            ST_NORMAL: begin
                if (BOOST_EN && (starve_cnt_d == LIMIT)) begin
                    state_d = ST_BOOST;
                end
            end
            ST_BOOST: begin
                if (g_served) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    assign o_boost = (state_q == ST_BOOST);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port sram: video (read-only, default
// priority) and game (read/write), with a one-cycle tagged read return.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_v_req,
    input  logic [ADDR_WIDTH-1:0] i_v_addr,
    output logic                  o_v_gnt,
    output logic                  o_v_rvalid,
    output logic [DATA_WIDTH-1:0] o_v_rdata,

    input  logic                  i_g_req,
    input  logic                  i_g_write,
    input  logic [ADDR_WIDTH-1:0] i_g_addr,
    input  logic [DATA_WIDTH-1:0] i_g_wdata,
    output logic                  o_g_gnt,
    output logic                  o_g_rvalid,
    output logic [DATA_WIDTH-1:0] o_g_rdata,

    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    // Handshake: a transfer happens in any cycle where req && gnt; the
    // requester holds req/addr/data until then. gnt is combinational from req
    // and the boost state, at most one is high, and both are 0 during reset.

    logic   boost;
    logic   v_gnt, g_gnt;
    owner_e owner_q, owner_d;

    starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_guard (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_g_req (i_g_req),
        .i_g_gnt (g_gnt),
        .o_boost (boost)
    );

    assign v_gnt = !i_rst && i_v_req && (!boost || !i_g_req);
    assign g_gnt = !i_rst && i_g_req && ( boost || !i_v_req);

    assign o_v_gnt = v_gnt;
    assign o_g_gnt = g_gnt;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_write = 1'b0;
        o_mem_wdata = '0;
        if (v_gnt) begin
            o_mem_addr = i_v_addr;
        end else if (g_gnt) begin
            o_mem_addr  = i_g_addr;
            o_mem_write = i_g_write;
            o_mem_wdata = i_g_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (v_gnt) begin
            owner_d = OWN_VIDEO;
        end else if (g_gnt && !i_g_write) begin
            owner_d = OWN_GAME;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // sram data lands one cycle after the grant; only its owner sees it.
    assign o_v_rvalid = (owner_q == OWN_VIDEO);
    assign o_g_rvalid = (owner_q == OWN_GAME);
    assign o_v_rdata  = o_v_rvalid ? i_mem_rdata : '0;
    assign o_g_rdata  = o_g_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with STARVE_LIMIT=4 and one
// with STARVE_LIMIT=0, each backed by its own behavioural sram.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW = 9;
    localparam int DW = 1;

    logic          clk;
    logic          rst;
    logic          mem_clr;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          g_req;
    logic          g_write;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    logic          v_gnt4, v_rvalid4, g_gnt4, g_rvalid4, mem_write4;
    logic [DW-1:0] v_rdata4, g_rdata4, mem_wdata4, mem_rdata4;
    logic [AW-1:0] mem_addr4;
    logic          v_gnt0, v_rvalid0, g_gnt0, g_rvalid0, mem_write0;
    logic [DW-1:0] v_rdata0, g_rdata0, mem_wdata0, mem_rdata0;
    logic [AW-1:0] mem_addr0;

    logic [DW-1:0] mem4 [512];
    logic [DW-1:0] mem0 [512];

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_v_req(v_req), .i_v_addr(v_addr), .o_v_gnt(v_gnt4),
        .o_v_rvalid(v_rvalid4), .o_v_rdata(v_rdata4),
        .i_g_req(g_req), .i_g_write(g_write), .i_g_addr(g_addr),
        .i_g_wdata(g_wdata), .o_g_gnt(g_gnt4),
        .o_g_rvalid(g_rvalid4), .o_g_rdata(g_rdata4),
        .o_mem_addr(mem_addr4), .o_mem_write(mem_write4),
        .o_mem_wdata(mem_wdata4), .i_mem_rdata(mem_rdata4)
    );

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_v_req(v_req), .i_v_addr(v_addr), .o_v_gnt(v_gnt0),
        .o_v_rvalid(v_rvalid0), .o_v_rdata(v_rdata0),
        .i_g_req(g_req), .i_g_write(g_write), .i_g_addr(g_addr),
        .i_g_wdata(g_wdata), .o_g_gnt(g_gnt0),
        .o_g_rvalid(g_rvalid0), .o_g_rdata(g_rdata0),
        .o_mem_addr(mem_addr0), .o_mem_write(mem_write0),
        .o_mem_wdata(mem_wdata0), .i_mem_rdata(mem_rdata0)
    );

    // Behavioural single-port sram: write commits at the edge, registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem4[i] <= '0;
        end else if (mem_write4) begin
            mem4[mem_addr4] <= mem_wdata4;
        end
        mem_rdata4 <= mem4[mem_addr4];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem0[i] <= '0;
        end else if (mem_write0) begin
            mem0[mem_addr0] <= mem_wdata0;
        end
        mem_rdata0 <= mem0[mem_addr0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vr, input logic [AW-1:0] va, input logic gr,
                         input logic gw, input logic [AW-1:0] ga, input logic [DW-1:0] gd);
        @(posedge clk);
        #1;
        v_req   = vr;
        v_addr  = va;
        g_req   = gr;
        g_write = gw;
        g_addr  = ga;
        g_wdata = gd;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        v_req = 1'b1; v_addr = '0; g_req = 1'b1; g_write = 1'b0; g_addr = '0; g_wdata = '0;

        // Reset state, with both requesting: grants must stay low.
        @(negedge clk);
        chk1("rst_v_gnt", v_gnt4, 1'b0);
        chk1("rst_g_gnt", g_gnt4, 1'b0);
        chk1("rst_v_rvalid", v_rvalid4, 1'b0);
        chk1("rst_g_rvalid", g_rvalid4, 1'b0);
        chk1("rst_v_rdata", v_rdata4, 1'b0);
        chk1("rst_g_rdata", g_rdata4, 1'b0);
        chk1("rst_mem_write", mem_write4, 1'b0);
        chkn("rst_state", 32'(dut4.u_guard.state_q), 32'(ST_NORMAL));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0; v_req = 1'b0; g_req = 1'b0;

        // Video-only reads at 0..3, then one idle cycle for the last return.
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, AW'(i), 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (i < 4) begin
                chk1($sformatf("vonly_gnt_%0d", i), v_gnt4, 1'b1);
                chkn($sformatf("vonly_addr_%0d", i), 32'(mem_addr4), 32'(i));
            end
            chk1($sformatf("vonly_g_gnt_%0d", i), g_gnt4, 1'b0);
            chk1($sformatf("vonly_g_rvalid_%0d", i), g_rvalid4, 1'b0);
            chk1($sformatf("vonly_v_rvalid_%0d", i), v_rvalid4, i > 0);
            chk1($sformatf("vonly_v_rdata_%0d", i), v_rdata4, 1'b0);
        end

        // Game write 1 to addr 5, then read it back next cycle.
        drive(1'b0, '0, 1'b1, 1'b1, AW'(5), 1'b1);
        @(negedge clk);
        chk1("gw_gnt", g_gnt4, 1'b1);
        chk1("gw_mem_write", mem_write4, 1'b1);
        chkn("gw_mem_addr", 32'(mem_addr4), 32'd5);
        chk1("gw_mem_wdata", mem_wdata4, 1'b1);
        chk1("gw_v_rvalid", v_rvalid4, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, AW'(5), 1'b0);
        @(negedge clk);
        chk1("gr_gnt", g_gnt4, 1'b1);
        chk1("gr_mem_write", mem_write4, 1'b0);
        chk1("gw_no_rvalid", g_rvalid4, 1'b0);
        drive(1'b1, AW'(5), 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("gr_rvalid", g_rvalid4, 1'b1);
        chk1("gr_rdata", g_rdata4, 1'b1);
        chk1("gr_v_rvalid", v_rvalid4, 1'b0);
        chk1("vr5_gnt", v_gnt4, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("vr5_rvalid", v_rvalid4, 1'b1);
        chk1("vr5_rdata", v_rdata4, 1'b1);
        chk1("vr5_g_rvalid", g_rvalid4, 1'b0);
        chk1("vr5_g_rdata", g_rdata4, 1'b0);

        // Both requesting: V,V,V,V,G with limit 4; video only with limit 0.
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, AW'(1), 1'b1, 1'b0, AW'(7), 1'b0);
            @(negedge clk);
            chk1($sformatf("both4_g_gnt_%0d", j), g_gnt4, (j % 5) == 4);
            chk1($sformatf("both4_v_gnt_%0d", j), v_gnt4, (j % 5) != 4);
            chk1($sformatf("both4_g_rvalid_%0d", j), g_rvalid4, ((j % 5) == 0) && (j > 0));
            chk1($sformatf("both0_v_gnt_%0d", j), v_gnt0, 1'b1);
            chk1($sformatf("both0_g_gnt_%0d", j), g_gnt0, 1'b0);
            chkn($sformatf("both0_state_%0d", j), 32'(dut0.u_guard.state_q), 32'(ST_NORMAL));
        end

        // Game drops its request while boosted: no game grant, back to NORMAL.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, AW'(1), 1'b1, 1'b0, AW'(7), 1'b0);
            @(negedge clk);
            chk1($sformatf("pre_drop_v_gnt_%0d", k), v_gnt4, 1'b1);
        end
        drive(1'b1, AW'(1), 1'b0, 1'b0, AW'(7), 1'b0);
        @(negedge clk);
        chkn("drop_state_boost", 32'(dut4.u_guard.state_q), 32'(ST_BOOST));
        chk1("drop_v_gnt", v_gnt4, 1'b1);
        chk1("drop_g_gnt", g_gnt4, 1'b0);
        drive(1'b1, AW'(1), 1'b1, 1'b0, AW'(7), 1'b0);
        @(negedge clk);
        chkn("post_drop_state", 32'(dut4.u_guard.state_q), 32'(ST_NORMAL));
        chk1("post_drop_v_gnt", v_gnt4, 1'b1);
        chk1("post_drop_g_gnt", g_gnt4, 1'b0);

        // Reset while a video read is in flight: its rvalid never appears.
        drive(1'b1, AW'(0), 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("inflight_gnt", v_gnt4, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rst_gates_v_gnt", v_gnt4, 1'b0);
        chk1("rst_gates_g_gnt", g_gnt4, 1'b0);
        @(posedge clk);
        #1;
        chk1("inflight_rvalid_dropped", v_rvalid4, 1'b0);
        rst = 1'b0;
        v_req = 1'b0;
        @(negedge clk);
        chk1("after_rst_rvalid", v_rvalid4, 1'b0);
        chkn("after_rst_state", 32'(dut4.u_guard.state_q), 32'(ST_NORMAL));
        drive(1'b1, AW'(5), 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("after_rst_gnt", v_gnt4, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("after_rst_read_rvalid", v_rvalid4, 1'b1);
        chk1("after_rst_read_rdata", v_rdata4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
